// File: rtl/binary_to_gray.sv
// Registered binary-to-Gray converter.
// A WIDTH-bit binary word is sampled on every rising edge of i_clk and its
// reflected Gray code appears on o_gray one clock later. No input handshake:
// a new word is accepted every cycle, so throughput is one word per clock.
// o_valid rises on the first converting edge after reset and stays high
// until the next reset, telling downstream logic that o_gray is meaningful.
// Both outputs come straight from flops, so there is no combinational path
// from any input to any output.
module binary_to_gray #(
  parameter int WIDTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_binary,
  output logic [WIDTH-1:0] o_gray,
  output logic             o_valid
);

  logic [WIDTH-1:0] gray_next;

  // Gray encoding: MSB passes through, each lower bit is the XOR of itself
  // and its upper neighbour (same as i_binary ^ (i_binary >> 1)).
  always_comb begin
    gray_next = '0;
    gray_next[WIDTH-1] = i_binary[WIDTH-1];
    for (int k = WIDTH - 2; k >= 0; k--) begin
      gray_next[k] = i_binary[k+1] ^ i_binary[k];
    end
  end

  // Output register; reset has priority and clears both the code and valid.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_gray  <= '0;
      o_valid <= 1'b0;
    end else begin
      o_gray  <= gray_next;
      o_valid <= 1'b1;
    end
  end

endmodule

// File: tb/tb_binary_to_gray.sv
// Directed bench for binary_to_gray: a WIDTH=4 and a WIDTH=8 instance share
// clock and reset. Inputs are driven and outputs sampled 1 time unit after
// each rising edge, away from the active edge.
module tb_binary_to_gray;

  logic       clk;
  logic       rst;
  logic [3:0] bin4;
  logic [3:0] gray4;
  logic       valid4;
  logic [7:0] bin8;
  logic [7:0] gray8;
  logic       valid8;

  int n_checks;
  int n_errors;

  binary_to_gray #(.WIDTH(4)) u_dut4 (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_binary (bin4),
    .o_gray   (gray4),
    .o_valid  (valid4)
  );

  binary_to_gray #(.WIDTH(8)) u_dut8 (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_binary (bin8),
    .o_gray   (gray8),
    .o_valid  (valid8)
  );

  // Clock generation, period 10
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Single comparison point for the whole bench
  task automatic check_val(input string tag, input logic [31:0] obs,
                           input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h", tag, obs, exp);
    end
  endtask

  logic [3:0] vec_in  [4] = '{4'b0000, 4'b0101, 4'b1011, 4'b1111};
  logic [3:0] vec_exp [4] = '{4'b0000, 4'b0111, 4'b1110, 4'b1000};
  logic [7:0] v8_in   [3] = '{8'hFF, 8'h80, 8'hA5};
  logic [7:0] v8_exp  [3] = '{8'h80, 8'hC0, 8'hF7};

  initial begin
    logic [3:0] prev_gray;
    logic [3:0] b;
    n_checks = 0;
    n_errors = 0;
    rst  = 1'b1;
    bin4 = 4'b0000;
    bin8 = 8'h00;

    // Reset held for two edges
    tick();
    tick();
    check_val("rst_gray4", 32'(gray4), 32'h0);
    check_val("rst_valid4", 32'(valid4), 32'h0);
    check_val("rst_gray8", 32'(gray8), 32'h0);
    check_val("rst_valid8", 32'(valid8), 32'h0);

    // Release reset: valid rises after the next edge
    rst = 1'b0;
    tick();
    check_val("rel_valid4", 32'(valid4), 32'h1);
    check_val("rel_gray4", 32'(gray4), 32'h0);
    check_val("rel_valid8", 32'(valid8), 32'h1);

    // Directed vectors, one per clock
    for (int i = 0; i < 4; i++) begin
      bin4 = vec_in[i];
      tick();
      check_val($sformatf("vec4_%0d", i), 32'(gray4), 32'(vec_exp[i]));
    end

    // Sweep 0..15 then wrap to 0; each step must change exactly one bit
    bin4 = 4'd15;
    tick();
    prev_gray = gray4;
    for (int i = 0; i <= 16; i++) begin
      b = 4'(i);
      bin4 = b;
      tick();
      check_val($sformatf("sweep_%0d", i), 32'(gray4), 32'(b ^ (b >> 1)));
      check_val($sformatf("onebit_%0d", i), $countones(gray4 ^ prev_gray), 32'd1);
      prev_gray = gray4;
    end

    // Reset mid-stream while a non-zero value is presented
    bin4 = 4'b1011;
    rst  = 1'b1;
    tick();
    check_val("mid_rst_gray", 32'(gray4), 32'h0);
    check_val("mid_rst_valid", 32'(valid4), 32'h0);
    rst = 1'b0;
    tick();
    check_val("post_rst_gray", 32'(gray4), 32'hE);
    check_val("post_rst_valid", 32'(valid4), 32'h1);

    // Input change between edges must not reach the output
    bin4 = 4'b0101;
    tick();
    check_val("hold_load", 32'(gray4), 32'h7);
    bin4 = 4'b1111;
    #2;
    check_val("no_comb_path", 32'(gray4), 32'h7);
    bin4 = 4'b0101;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_val($sformatf("hold_%0d", i), 32'(gray4), 32'h7);
    end

    // WIDTH=8 instance
    for (int i = 0; i < 3; i++) begin
      bin8 = v8_in[i];
      tick();
      check_val($sformatf("vec8_%0d", i), 32'(gray8), 32'(v8_exp[i]));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/binary_to_gray.md
Name: binary_to_gray

Overview:
Registered binary-to-Gray code converter. It takes a WIDTH-bit binary word and produces the reflected Gray code of that word one clock later. It is used wherever a counter value must cross into logic that needs single-bit-change encoding, such as pointer synchronisers and encoder interfaces. All outputs are registered on a single clock.

Parameters:
- WIDTH, 4, bit width of the binary input and the Gray output; legal values are 2 to 32.

Ports:
- i_clk, input, 1, system clock; all state updates on its rising edge.
- i_rst, input, 1, synchronous, active-high reset.
- i_binary, input, WIDTH, binary value to convert; sampled on every rising edge.
- o_gray, output, WIDTH, registered Gray code of the i_binary value sampled at the previous edge.
- o_valid, output, 1, high once o_gray holds a converted value; it is an optional port and may be left unconnected.

Behaviour:
- Reset (synchronous, active-high): on any rising edge with i_rst=1, o_gray becomes all zeros and o_valid becomes 0. Reset has priority over conversion.
- Conversion: on each rising edge with i_rst=0:
  - o_gray[WIDTH-1] <= i_binary[WIDTH-1].
  - o_gray[k] <= i_binary[k+1] XOR i_binary[k], for k = WIDTH-2 down to 0.
  - Equivalently, o_gray <= i_binary XOR (i_binary >> 1), a logical shift with zero fill.
- o_valid: set to 1 on the first rising edge with i_rst=0 after reset, and stays 1 until the next reset.
- Latency: exactly 1 clock from i_binary to o_gray. There is no input handshake; a new value is accepted every cycle (throughput 1 per clock).
- No combinational path from any input to any output.
- Reset mid-stream: the edge on which i_rst=1 forces o_gray to 0 regardless of i_binary. The first edge after i_rst falls converts the i_binary present at that edge.
- Input held constant: o_gray holds its value with no glitches.
- Boundary values:
  - An all-zero input gives all-zero Gray.
  - An all-ones input gives MSB=1 with all other bits 0.
  - Wrap from 2^WIDTH-1 to 0 changes a single output bit, the MSB.
- Successive binary values differing by +1 or -1, including the wrap, produce o_gray values differing in exactly one bit.
- Before the first reset, o_gray and o_valid are undefined; the bench must apply reset first.

Test Plan:
- Hold i_rst=1 for 2 edges with i_binary=0000 -> o_gray=0000 and o_valid=0. Release reset -> o_valid=1 after the next edge.
- Apply 0000, 0101, 1011, 1111, one value per clock, each sampled 1 clock later -> o_gray = 0000, 0111, 1110, 1000.
- Exhaustive sweep of 0..15 with a compare against the bin XOR (bin>>1) model -> every output matches. Each consecutive output differs in exactly 1 bit, including the wrap 1111 -> 0000 (Gray 1000 -> 0000).
- Assert i_rst=1 while i_binary=1011 mid-stream -> o_gray=0000 and o_valid=0 on that edge. After release -> the next edge gives o_gray=1110.
- Change i_binary between clock edges -> o_gray changes only at the rising edge (no combinational path). Hold 0101 for 5 clocks -> o_gray stays at 0111.
- WIDTH=8 instance: inputs 8'hFF, 8'h80 and 8'hA5 -> o_gray = 8'h80, 8'hC0 and 8'hF7.
